// File: rtl/imem_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface imem_if #(
   parameter int PC_WIDTH    = 32,
   parameter int INSTR_WIDTH = 32
);
   logic                   req;
   logic [PC_WIDTH-1:0]    addr;
   logic                   ack;
   logic [INSTR_WIDTH-1:0] rdata;

   modport master (
      output req,
      output addr,
      input  ack,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output ack,
      output rdata
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the architectural PC, fetches over the imem req/ack bus and
// holds the fetched word for decode; an unresponsive memory latches a sticky fault.
module instr_fetch_unit #(
   parameter int                  PC_WIDTH    = 32,
   parameter int                  INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = {PC_WIDTH{1'b0}},
   parameter int                  MAX_WAIT    = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [PC_WIDTH-1:0]    incr_pc,
   input  logic                   pc_load,
   input  logic                   stall,
   input  logic                   flush,
   imem_if.master                 imem,
   output logic [PC_WIDTH-1:0]    pc,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic                   instr_valid,
   output logic                   fetch_busy,
   output logic                   fetch_fault
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_VALID = 2'd2;
   localparam logic [1:0] ST_FAULT = 2'd3;

   // Counter only has to reach MAX_WAIT; it stops there because the FSM leaves REQ.
   localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   logic [1:0]             state_r, state_s;
   logic [PC_WIDTH-1:0]    pc_r, pc_s;
   logic [INSTR_WIDTH-1:0] instr_r, instr_s;
   logic                   valid_r, valid_s;
   logic                   fault_r, fault_s;
   logic [WAIT_W-1:0]      wait_r, wait_s;

   // Next-state and datapath selection for every fetch state.
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      instr_s = instr_r;
      valid_s = valid_r;
      fault_s = fault_r;
      wait_s  = wait_r;
      case (state_r)
         ST_IDLE: begin
            if (flush) begin
               pc_s = incr_pc;
            end else begin
               pc_s = pc_r;
            end
            state_s = ST_REQ;
         end
         ST_REQ: begin
            // Flush beats a same-cycle ack: the returned word belongs to the old PC.
            if (flush) begin
               pc_s    = incr_pc;
               valid_s = 1'b0;
               wait_s  = {WAIT_W{1'b0}};
               state_s = ST_REQ;
            end else if (imem.ack) begin
               instr_s = imem.rdata;
               valid_s = 1'b1;
               wait_s  = {WAIT_W{1'b0}};
               state_s = ST_VALID;
            end else if (wait_r == WAIT_W'(MAX_WAIT)) begin
               valid_s = 1'b0;
               fault_s = 1'b1;
               state_s = ST_FAULT;
            end else begin
               wait_s = wait_r + WAIT_W'(1);
            end
         end
         ST_VALID: begin
            if (flush) begin
               pc_s    = incr_pc;
               valid_s = 1'b0;
               wait_s  = {WAIT_W{1'b0}};
               state_s = ST_REQ;
            end else if (pc_load && !stall) begin
               pc_s    = incr_pc;
               valid_s = 1'b0;
               wait_s  = {WAIT_W{1'b0}};
               state_s = ST_REQ;
            end else begin
               state_s = ST_VALID;
            end
         end
         ST_FAULT: begin
            valid_s = 1'b0;
            fault_s = 1'b1;
            state_s = ST_FAULT;
         end
         default: begin
            valid_s = 1'b0;
            fault_s = 1'b1;
            state_s = ST_FAULT;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         pc_r    <= RESET_PC;
         instr_r <= {INSTR_WIDTH{1'b0}};
         valid_r <= 1'b0;
         fault_r <= 1'b0;
         wait_r  <= {WAIT_W{1'b0}};
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         instr_r <= instr_s;
         valid_r <= valid_s;
         fault_r <= fault_s;
         wait_r  <= wait_s;
      end
   end

   assign imem.req    = (state_r == ST_REQ);
   assign imem.addr   = pc_r;
   assign fetch_busy  = (state_r == ST_REQ);
   assign pc          = pc_r;
   assign instr       = instr_r;
   assign instr_valid = valid_r;
   assign fetch_fault = fault_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural fetch model.
module tb_instr_fetch_unit;
   localparam int PW = 32;
   localparam int IW = 32;
   localparam int MAX_WAIT = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic [PW-1:0] incr_pc;
   logic          pc_load, stall, flush;
   logic [PW-1:0] pc;
   logic [IW-1:0] instr;
   logic          instr_valid, fetch_busy, fetch_fault;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_on = 1'b0;

   imem_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) imem ();

   instr_fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(32'h0000_0000),
                      .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .incr_pc(incr_pc), .pc_load(pc_load), .stall(stall),
      .flush(flush), .imem(imem.master), .pc(pc), .instr(instr),
      .instr_valid(instr_valid), .fetch_busy(fetch_busy), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   // Behavioural model: "boot" is the one idle cycle after reset, "have" means a
   // word is held for decode, otherwise the unit is requesting (unless faulted).
   logic [PW-1:0] m_pc, n_pc;
   logic [IW-1:0] m_instr, n_instr;
   bit            m_boot, n_boot, m_have, n_have, m_fault, n_fault;
   int            m_unacked, n_unacked;

   always_comb begin
      n_pc = m_pc; n_instr = m_instr; n_boot = m_boot; n_have = m_have;
      n_fault = m_fault; n_unacked = m_unacked;
      if (reset) begin
         n_pc = 32'h0; n_instr = 32'h0; n_boot = 1'b1; n_have = 1'b0;
         n_fault = 1'b0; n_unacked = 0;
      end else if (m_fault) begin
         n_fault = 1'b1;
      end else if (m_boot) begin
         if (flush) n_pc = incr_pc;
         else n_pc = m_pc;
         n_boot = 1'b0;
      end else if (flush) begin
         n_pc = incr_pc; n_have = 1'b0; n_unacked = 0;
      end else if (!m_have) begin
         if (imem.ack) begin
            n_instr = imem.rdata; n_have = 1'b1; n_unacked = 0;
         end else begin
            n_unacked = m_unacked + 1;
            if (n_unacked > MAX_WAIT) n_fault = 1'b1;
            else n_fault = 1'b0;
         end
      end else if (pc_load && !stall) begin
         n_pc = incr_pc; n_have = 1'b0;
      end else begin
         n_have = 1'b1;
      end
   end

   always @(posedge clk) begin
      m_pc <= n_pc; m_instr <= n_instr; m_boot <= n_boot; m_have <= n_have;
      m_fault <= n_fault; m_unacked <= n_unacked;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison of every output against the model, away from the edge.
   always @(negedge clk) begin
      if (cmp_on) begin
         check("m_req",   {63'd0, imem.req}, {63'd0, !m_boot && !m_have && !m_fault});
         check("m_addr",  {32'd0, imem.addr}, {32'd0, m_pc});
         check("m_pc",    {32'd0, pc}, {32'd0, m_pc});
         check("m_instr", {32'd0, instr}, {32'd0, m_instr});
         check("m_valid", {63'd0, instr_valid}, {63'd0, m_have && !m_fault});
         check("m_busy",  {63'd0, fetch_busy}, {63'd0, !m_boot && !m_have && !m_fault});
         check("m_fault", {63'd0, fetch_fault}, {63'd0, m_fault});
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int ack_pct;
      reset = 1'b1; incr_pc = 32'h0; pc_load = 1'b0; stall = 1'b0; flush = 1'b0;
      imem.ack = 1'b0; imem.rdata = 32'h0;
      step(2);
      cmp_on = 1'b1;
      check("rst_pc", {32'd0, pc}, 64'd0);
      check("rst_req", {63'd0, imem.req}, 64'd0);
      check("rst_valid", {63'd0, instr_valid}, 64'd0);
      check("rst_fault", {63'd0, fetch_fault}, 64'd0);
      check("rst_instr", {32'd0, instr}, 64'd0);

      // 1: first fetch with zero-wait ack
      reset = 1'b0;
      step(1);
      check("t1_req", {63'd0, imem.req}, 64'd1);
      check("t1_addr", {32'd0, imem.addr}, 64'd0);
      imem.ack = 1'b1; imem.rdata = 32'hA5A5_0001;
      step(1);
      imem.ack = 1'b0;
      check("t1_instr", {32'd0, instr}, 64'hA5A5_0001);
      check("t1_valid", {63'd0, instr_valid}, 64'd1);

      // 2: stall overrides pc_load
      incr_pc = 32'h1; pc_load = 1'b1; stall = 1'b1;
      step(3);
      check("t2_pc_stall", {32'd0, pc}, 64'd0);
      check("t2_valid_stall", {63'd0, instr_valid}, 64'd1);
      stall = 1'b0;
      step(1);
      pc_load = 1'b0;
      check("t2_pc", {32'd0, pc}, 64'd1);
      check("t2_req", {63'd0, imem.req}, 64'd1);
      check("t2_addr", {32'd0, imem.addr}, 64'd1);

      // 3: flush beats same-cycle ack at pc=5
      flush = 1'b1; incr_pc = 32'h5;
      step(1);
      check("t3_pc5", {32'd0, pc}, 64'd5);
      imem.ack = 1'b1; imem.rdata = 32'hDEAD_BEEF; incr_pc = 32'h40;
      step(1);
      imem.ack = 1'b0; flush = 1'b0;
      check("t3_valid", {63'd0, instr_valid}, 64'd0);
      check("t3_instr", {32'd0, instr}, 64'hA5A5_0001);
      check("t3_addr", {32'd0, imem.addr}, 64'h40);
      check("t3_req", {63'd0, imem.req}, 64'd1);

      // 4: timeout after MAX_WAIT+1 unacked cycles
      step(15);
      check("t4_nofault15", {63'd0, fetch_fault}, 64'd0);
      step(1);
      check("t4_fault", {63'd0, fetch_fault}, 64'd1);
      check("t4_req", {63'd0, imem.req}, 64'd0);
      pc_load = 1'b1; flush = 1'b1; incr_pc = 32'h77;
      step(2);
      pc_load = 1'b0; flush = 1'b0;
      check("t4_pc_frozen", {32'd0, pc}, 64'h40);
      check("t4_still", {63'd0, fetch_fault}, 64'd1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("t4_clr", {63'd0, fetch_fault}, 64'd0);
      check("t4_pc0", {32'd0, pc}, 64'd0);

      // 5: reset mid-handshake drops the returned word
      step(1);
      reset = 1'b1; imem.ack = 1'b1; imem.rdata = 32'h0000_BEEF;
      step(1);
      reset = 1'b0; imem.ack = 1'b0;
      check("t5_instr", {32'd0, instr}, 64'd0);
      check("t5_req", {63'd0, imem.req}, 64'd0);
      check("t5_valid", {63'd0, instr_valid}, 64'd0);

      // 6: PC extremes
      step(1);
      imem.ack = 1'b1; imem.rdata = 32'h1234_5678;
      step(1);
      imem.ack = 1'b0; incr_pc = 32'hFFFF_FFFF; pc_load = 1'b1;
      step(1);
      pc_load = 1'b0;
      check("t6_addr_max", {32'd0, imem.addr}, 64'hFFFF_FFFF);
      imem.ack = 1'b1;
      step(1);
      imem.ack = 1'b0; incr_pc = 32'h0; pc_load = 1'b1;
      step(1);
      pc_load = 1'b0;
      check("t6_addr0", {32'd0, imem.addr}, 64'd0);
      check("t6_fault", {63'd0, fetch_fault}, 64'd0);
      check("t6_valid", {63'd0, instr_valid}, 64'd0);

      // Randomized traffic; every third segment uses a sluggish memory to hit timeouts.
      for (int seg = 0; seg < 12; seg++) begin
         ack_pct = (seg % 3 == 2) ? 5 : 75;
         reset = 1'b1;
         step(1);
         for (int i = 0; i < 200; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            pc_load    = $urandom_range(0, 1) == 1;
            imem.ack   = ($urandom_range(0, 99) < ack_pct);
            imem.rdata = $urandom;
            incr_pc    = $urandom;
            step(1);
         end
      end
      reset = 1'b0; flush = 1'b0; pc_load = 1'b0; stall = 1'b0; imem.ack = 1'b0;
      step(1);
      cmp_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
